// File: rtl/parking_pkg.sv
// Shared types and sizes for the parking gate controller.
// Purely declarative: no logic, no latency, no backpressure.
package parking_pkg;

    localparam int NUM_SPOTS = 8;
    localparam int SPOT_W    = 3;
    localparam int COUNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY_GATE,
        EXIT_GATE
    } gate_state_t;

    typedef enum logic {
        ENTRY,
        EXIT
    } served_t;

endpackage

// File: rtl/spot_picker.sv
// Highest-set-bit encoder: picks the highest-numbered free spot.
// Combinational, zero latency; no backpressure (vld=0 when the map is empty).
module spot_picker
    import parking_pkg::*;
(
    input  logic [NUM_SPOTS-1:0] map,
    output logic [SPOT_W-1:0]    idx,
    output logic                 vld
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (map[i]) idx = SPOT_W'(i);
        end
    end

    assign vld = |map;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Shared-gate controller for an 8-spot lot: owns occupancy, arbitrates entry/exit round-robin.
// Latency: ack and gate_open registered at the grant edge; gate held GATE_CYCLES cycles.
// Backpressure: requests are level-held; entry waits while full, nothing sampled outside IDLE.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SPOT_W-1:0]    exit_spot,
    output logic                 entry_ack,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [SPOT_W-1:0]    park_number,
    output logic                 gate_open,
    output logic [NUM_SPOTS-1:0] free_map,
    output logic [COUNT_W-1:0]   free_count,
    output logic                 full
);

    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_CYCLES - 1);

    gate_state_t       state;
    served_t           last_served;
    logic [CNT_W-1:0]  cnt;
    logic [SPOT_W-1:0] pick_idx;
    logic              pick_vld;
    logic              entry_ok;
    logic              serve_exit;
    logic              serve_entry;

    spot_picker u_spot_picker (
        .map (free_map),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // An entry only competes when a spot exists; on a tie the type not served last wins.
    assign entry_ok    = entry_req && pick_vld;
    assign serve_exit  = exit_req && (!entry_ok || (last_served == ENTRY));
    assign serve_entry = entry_ok && !serve_exit;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (free_map[i]) free_count = free_count + COUNT_W'(1);
        end
    end

    assign full = (free_map == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= EXIT;
            cnt         <= '0;
            free_map    <= '1;
            park_number <= '0;
            entry_ack   <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;
            gate_open   <= 1'b0;
        end else begin
            entry_ack <= 1'b0;
            exit_ack  <= 1'b0;
            exit_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve_exit) begin
                        exit_ack    <= 1'b1;
                        last_served <= EXIT;
                        // Vacating an already-free spot is flagged and consumed without opening the gate.
                        if (free_map[exit_spot]) begin
                            exit_err <= 1'b1;
                        end else begin
                            free_map[exit_spot] <= 1'b1;
                            gate_open           <= 1'b1;
                            cnt                 <= CNT_LOAD;
                            state               <= EXIT_GATE;
                        end
                    end else if (serve_entry) begin
                        free_map[pick_idx] <= 1'b0;
                        park_number        <= pick_idx;
                        entry_ack          <= 1'b1;
                        gate_open          <= 1'b1;
                        cnt                <= CNT_LOAD;
                        state              <= ENTRY_GATE;
                        last_served        <= ENTRY;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        gate_open <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: scoreboard of expected grants, popped on each ack.
module tb_parking_gate_ctrl;

    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_spot;
    logic       entry_ack;
    logic       exit_ack;
    logic       exit_err;
    logic [2:0] park_number;
    logic       gate_open;
    logic [7:0] free_map;
    logic [3:0] free_count;
    logic       full;

    parking_gate_ctrl #(.GATE_CYCLES(GC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .exit_spot   (exit_spot),
        .entry_ack   (entry_ack),
        .exit_ack    (exit_ack),
        .exit_err    (exit_err),
        .park_number (park_number),
        .gate_open   (gate_open),
        .free_map    (free_map),
        .free_count  (free_count),
        .full        (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_entry;
        logic [2:0] park;
        logic [7:0] map;
        bit         err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_map;
    int         checks   = 0;
    int         errors   = 0;
    int         acks     = 0;
    int         gate_run = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_entry();
        int s = 0;
        for (int i = 0; i < 8; i++) if (model_map[i]) s = i;
        model_map[s] = 1'b0;
        sb.push_back('{1'b1, 3'(s), model_map, 1'b0});
    endtask

    task automatic push_exit(input int s);
        bit e = model_map[s];
        model_map[s] = 1'b1;
        sb.push_back('{1'b0, 3'(s), model_map, e});
    endtask

    // One cycle: sample at the falling edge, score any ack, drop acked requests.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            gate_run = 0;
        end else begin
            if (gate_open) begin
                gate_run++;
            end else if (gate_run != 0) begin
                check("gate_len", gate_run, GC);
                gate_run = 0;
            end
            if (entry_ack || exit_ack) begin
                acks++;
                check("dual_ack", int'(entry_ack && exit_ack), 0);
                check("ack_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("ack_kind", int'(entry_ack), int'(e.is_entry));
                    if (e.is_entry) check("park_number", park_number, e.park);
                    check("free_map", free_map, e.map);
                    check("exit_err", int'(exit_err), int'(e.err));
                    check("gate_at_ack", int'(gate_open), int'(!e.err));
                end
                if (entry_ack) entry_req = 1'b0;
                if (exit_ack)  exit_req  = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            step();
            n++;
        end while (n < 200 && !(sb.size() == 0 && !gate_open && !entry_req && !exit_req));
        check("idle_in_budget", int'(n < 200), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        sb.delete();
        model_map = 8'hFF;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_spot = 3'd0;
        model_map = 8'hFF;
        step();
        check("rst_free_map", free_map, 8'hFF);
        check("rst_free_count", free_count, 8);
        check("rst_full", full, 0);
        check("rst_gate", gate_open, 0);
        check("rst_park", park_number, 0);
        check("rst_acks", int'(entry_ack | exit_ack | exit_err), 0);
        rst_n = 1'b1;

        push_entry();
        entry_req = 1'b1;
        wait_idle();
        check("first_park", park_number, 7);
        check("first_count", free_count, 7);

        for (int k = 0; k < 7; k++) begin
            push_entry();
            entry_req = 1'b1;
            wait_idle();
        end
        check("full_flag", full, 1);
        check("full_count", free_count, 0);

        n = acks;
        entry_req = 1'b1;
        repeat (20) step();
        check("full_no_ack", acks, n);
        check("full_req_held", int'(entry_req), 1);

        push_exit(3);
        push_entry();
        exit_spot = 3'd3;
        exit_req  = 1'b1;
        wait_idle();
        check("held_entry_park", park_number, 3);

        foreach (model_map[i]) begin end
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (k == 0) ? 5 : (k == 1) ? 3 : 2;
            push_exit(s);
            exit_spot = 3'(s);
            exit_req  = 1'b1;
            wait_idle();
        end
        check("preload_map", free_map, 8'b0010_1100);

        push_entry();
        entry_req = 1'b1;
        wait_idle();
        check("preload_park", park_number, 5);
        check("preload_after", free_map, 8'b0000_1100);

        push_exit(2);
        exit_spot = 3'd2;
        exit_req  = 1'b1;
        wait_idle();
        check("err_map_same", free_map, 8'b0000_1100);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_entry();
            push_exit(7);
            exit_spot = 3'd7;
            entry_req = 1'b1;
            exit_req  = 1'b1;
            wait_idle();
        end
        push_entry();
        entry_req = 1'b1;
        wait_idle();
        push_exit(7);
        push_entry();
        exit_spot = 3'd7;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        wait_idle();
        check("tie_final_map", free_map, 8'h7F);

        do_reset();
        push_entry();
        entry_req = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("mid_ack_seen", sb.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gate", gate_open, 0);
        check("mid_rst_map", free_map, 8'hFF);
        check("mid_rst_count", free_count, 8);
        check("mid_rst_ack", int'(entry_ack | exit_ack), 0);
        step();
        step();
        model_map = 8'hFF;
        rst_n = 1'b1;
        n = acks;
        repeat (10) step();
        check("post_rst_no_ack", acks, n);
        check("post_rst_gate", gate_open, 0);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Sequential controller for a single shared gate serving an 8-spot lot. It holds the spot-occupancy map and arbitrates between entry and exit requests, with round-robin on conflict. For each entry it allocates the highest-numbered free spot and holds the gate open for a fixed number of cycles. It sits between the entry/exit sensor logic and the gate actuator, and is the sole owner of the occupancy state.

## Interface
- NUM_SPOTS, 8: number of spots. Fixed at 8 for this revision.
- GATE_CYCLES, 4: cycles the gate stays open per granted request. Must be at least 1.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- entry_req  in  1  car waiting at entry; level, held until entry_ack
- exit_req  in  1  car waiting at exit; level, held until exit_ack
- exit_spot  in  3  spot index being vacated; valid while exit_req=1
- entry_ack  out  1  one-cycle pulse: entry granted
- exit_ack  out  1  one-cycle pulse: exit request consumed
- exit_err  out  1  one-cycle pulse with exit_ack: exit_spot was already free
- park_number  out  3  spot allocated by the last entry grant; holds until next grant
- gate_open  out  1  gate actuator drive
- free_map  out  8  occupancy register; bit i=1 means spot i is free
- free_count  out  4  number of free spots (0..8)
- full  out  1  free_map == 0

## Operation
- States: IDLE, ENTRY_GATE, EXIT_GATE.
- Requests are sampled only in IDLE.
- IDLE arbitration at each edge:
  - Exit only: serve the exit.
  - Entry only and !full: serve the entry.
  - Both valid (entry valid only if !full): serve the type not served last. The last_served flag resets to EXIT, so the first tie goes to entry.
  - Entry while full: not served and not acknowledged. The request waits.
- Entry grant, one edge, all effects together:
  - Clear free_map[spot], where spot is the highest set bit of free_map.
  - park_number <= spot; entry_ack = 1; gate_open = 1.
  - cnt <= GATE_CYCLES-1; state -> ENTRY_GATE; last_served <= ENTRY.
- Exit grant with free_map[exit_spot]=0:
  - Set the bit; exit_ack = 1; gate_open = 1.
  - cnt loaded as for entry; state -> EXIT_GATE; last_served <= EXIT.
- Exit grant with free_map[exit_spot]=1:
  - exit_ack = 1 and exit_err = 1; no map change; no gate opening.
  - State stays IDLE; last_served <= EXIT.
- ENTRY_GATE / EXIT_GATE:
  - cnt decrements each edge.
  - At the edge where cnt==0: gate_open <= 0 and state -> IDLE.
- free_count and full are combinational from the free_map register.
- Requester rule: deassert the request in the cycle after the ack. A request still high when the controller next evaluates in IDLE is treated as a new request.

## Timing
- Reset values: state IDLE, free_map 8'hFF, park_number 0, entry_ack/exit_ack/exit_err/gate_open 0, cnt 0, last_served EXIT. Derived outputs: free_count 8, full 0.
- Reset asserted mid-operation: the gate closes immediately, all spots become free, and any pending ack is dropped.
- Grant latency: a request present before edge k in IDLE produces ack and gate_open visible from edge k (registered, 1-cycle ack).
- gate_open stays high for exactly GATE_CYCLES cycles.
- The next request is sampled no earlier than edge k+GATE_CYCLES+1.
- The erroneous-exit path occupies IDLE for a single cycle; a new request can be sampled at edge k+1.
- Map updates are visible on free_map/free_count from the grant edge.

## Structure
- Shared package parking_pkg:
  - NUM_SPOTS and SPOT_W=3.
  - State enum: IDLE, ENTRY_GATE, EXIT_GATE.
  - last_served encoding: ENTRY/EXIT.
- Sub-module spot_picker: combinational highest-set-bit encoder, 8-bit map to 3-bit index plus valid. Instantiated once on free_map.
- Popcount, FSM, counter and map register live in parking_gate_ctrl.

## Test plan
- Reset then entry_req=1 (GATE_CYCLES=4): entry_ack pulse, park_number=7, free_map=8'h7F, free_count=7, gate_open high for exactly 4 cycles.
- Preload map 8'b00101100 via entries/exits, then entry: park_number=5, free_map=8'b00001100.
- Fill all 8 spots: full=1, free_count=0. A further entry_req gets no ack for 20 cycles. Then exit_spot=3: exit_ack, free_map=8'h08, gate cycle. After that gate cycle the held entry is granted with park_number=3.
- entry_req and exit_req (spot 7 occupied) raised together from reset:
  - entry is served first, then exit, then entry again on the next tie.
  - The acks alternate.
- exit_req with exit_spot=2 while spot 2 is free: exit_ack=exit_err=1 for one cycle, gate_open stays 0, free_map unchanged.
- Assert rst_n=0 during ENTRY_GATE cycle 2: gate_open drops immediately, free_map=8'hFF, no ack after release.
